// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and two's-complement helper for the divider
package div_pkg;
    localparam int DIV_W = 32;
    localparam int MAX_W = 64;
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    function automatic logic [MAX_W-1:0] cneg(input logic en, input logic [MAX_W-1:0] x);
        return en ? -x : x;
    endfunction
endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: EX-stage request/response bundle between pipeline (master) and divider (slave)
interface div_seq_ctrl_if #(parameter int WIDTH = div_pkg::DIV_W);
    logic             start_i;
    logic             signed_i;
    logic             cancel_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    modport master (output start_i, signed_i, cancel_i, dividend_i, divisor_i,
                    input busy_o, stall_o, done_o, quotient_o, remainder_o);
    modport slave (input start_i, signed_i, cancel_i, dividend_i, divisor_i,
                   output busy_o, stall_o, done_o, quotient_o, remainder_o);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring radix-2 iteration on {rem,quo}
module div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0] sh, diff;
    logic           borrow;
    assign sh = {rem, quo[WIDTH-1]};
    // one extra bit on the shifted remainder so a full-width divisor never overflows the trial
    assign {borrow, diff} = {1'b0, sh} - {2'b0, divisor};
    assign rem_n = WIDTH'(borrow ? sh : diff);
    assign quo_n = {quo[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative DIV/DIVU sequencer with stall and flush; DIV_ZERO_FAST_EN short-cuts divide by zero
module div_seq_ctrl import div_pkg::*; #(
    parameter int WIDTH = DIV_W,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic resetn,
    div_seq_ctrl_if.slave d
);
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    state_t           state, state_n;
    logic [WIDTH-1:0] rem, quo, dvsr, rem_s, quo_s, q_fix, r_fix, q_z, quotient, remainder;
    logic [CNT_W-1:0] cnt;
    logic             sgn, q_neg, r_neg, go, zero, busy;
    assign go    = d.start_i & ~d.cancel_i;
    assign zero  = d.divisor_i == '0;
    assign busy  = state inside {PREP, ITER, FIX};
    assign q_fix = WIDTH'(cneg(q_neg, MAX_W'(quo)));
    assign r_fix = WIDTH'(cneg(r_neg, MAX_W'(rem)));
    assign q_z   = (d.signed_i & d.dividend_i[WIDTH-1]) ? WIDTH'(1) : '1;
    assign d.busy_o      = busy;
    assign d.stall_o     = (state == IDLE && go) || busy;
    assign d.done_o      = state == DONE;
    assign d.quotient_o  = quotient;
    assign d.remainder_o = remainder;
    div_step #(.WIDTH(WIDTH)) u_step (.rem(rem), .quo(quo), .divisor(dvsr), .rem_n(rem_s), .quo_n(quo_s));
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? ((FAST && zero) ? DONE : PREP) : IDLE;
            PREP:    state_n = ITER;
            ITER:    state_n = (cnt == CNT_W'(WIDTH-1)) ? FIX : ITER;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (d.cancel_i) state_n = IDLE;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            sgn       <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    quo  <= d.dividend_i;
                    dvsr <= d.divisor_i;
                    sgn  <= d.signed_i;
                    if (FAST && go && zero) begin
                        quotient  <= q_z;
                        remainder <= d.dividend_i;
                    end
                end
                PREP: begin
                    quo   <= WIDTH'(cneg(sgn & quo[WIDTH-1], MAX_W'(quo)));
                    dvsr  <= WIDTH'(cneg(sgn & dvsr[WIDTH-1], MAX_W'(dvsr)));
                    rem   <= '0;
                    cnt   <= '0;
                    q_neg <= sgn & (quo[WIDTH-1] ^ dvsr[WIDTH-1]);
                    r_neg <= sgn & quo[WIDTH-1];
                end
                ITER: begin
                    rem <= rem_s;
                    quo <= quo_s;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!d.cancel_i) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and random divides against an arithmetic reference model
module tb_div_seq_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int total = 0;
    int bad = 0;
    int done_at, done_n, stall_n;
    logic stall_done, busy_last, stall_last;
    logic [31:0] eq = '0, er = '0;
    div_seq_ctrl_if bus ();
    div_seq_ctrl dut (.clk(clk), .resetn(resetn), .d(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 0) begin
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // cycle 0 is the cycle in which start_i is first presented
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int ncyc, input int cancel_at, input int hold);
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.signed_i   = s;
        bus.start_i    = 1'b1;
        done_at = -1; done_n = 0; stall_n = 0; stall_done = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            bus.cancel_i = (c == cancel_at);
            @(negedge clk);
            if (bus.stall_o) stall_n++;
            busy_last  = bus.busy_o;
            stall_last = bus.stall_o;
            if (bus.done_o) begin
                done_n++;
                if (done_at < 0) begin
                    done_at    = c;
                    stall_done = bus.stall_o;
                end
            end
            @(posedge clk);
            #1;
            bus.start_i = (c + 1 < hold);
        end
        bus.cancel_i = 1'b0;
        bus.start_i  = 1'b0;
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        int lat;
        lat = 35;
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) lat = 1;
`endif
        run(a, b, s, 40, -1, hold);
        model(a, b, s, eq, er);
        check({tag, "_done_at"}, done_at, lat);
        check({tag, "_done_n"}, done_n, 1);
        check({tag, "_stall_n"}, stall_n, lat);
        check({tag, "_stall_done"}, 32'(stall_done), 0);
        check({tag, "_stall_idle"}, 32'(stall_last), 0);
        check({tag, "_q"}, bus.quotient_o, eq);
        check({tag, "_r"}, bus.remainder_o, er);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.cancel_i = 1'b0;
        bus.dividend_i = '0; bus.divisor_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", bus.quotient_o, 0);
        check("rst_r", bus.remainder_o, 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_stall", 32'(bus.stall_o), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        op("u100_7", 32'd100, 32'd7, 1'b0, 1);
        check("u100_7_lit_q", bus.quotient_o, 32'h0000_000E);
        op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1);
        check("s_m7_2_lit_r", bus.remainder_o, 32'hFFFF_FFFF);
        op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1);
        check("s_7_m2_lit_q", bus.quotient_o, 32'hFFFF_FFFD);
        op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
        check("s_ovf_lit_q", bus.quotient_o, 32'h8000_0000);
        op("s_dz", 32'hFFFF_FFF0, 32'd0, 1'b1, 1);
        check("s_dz_lit_q", bus.quotient_o, 32'h0000_0001);
        op("u_dz", 32'd5, 32'd0, 1'b0, 1);
        // flush mid-ITER: no completion, previous result held, idle by cycle 11
        run(32'd100, 32'd7, 1'b0, 12, 10, 1);
        check("cxl_done_n", done_n, 0);
        check("cxl_busy11", 32'(busy_last), 0);
        check("cxl_stall11", 32'(stall_last), 0);
        check("cxl_q_held", bus.quotient_o, eq);
        check("cxl_r_held", bus.remainder_o, er);
        op("after_cxl", 32'd9, 32'd3, 1'b0, 1);
        op("hold_start", 32'd1234567, 32'd89, 1'b0, 36);
        // async reset part way through an operation
        run(32'd1000, 32'd3, 1'b0, 20, -1, 1);
        check("ar_busy_before", 32'(busy_last), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_q", bus.quotient_o, 0);
        check("ar_r", bus.remainder_o, 0);
        check("ar_busy", 32'(bus.busy_o), 0);
        check("ar_done", 32'(bus.done_o), 0);
        @(negedge clk);
        resetn = 1'b1;
        done_n = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) done_n++;
        end
        check("ar_quiet", done_n, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 65535));
                default: b = $urandom;
            endcase
            op($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)), 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
